// File: rtl/baud_tick_controller.sv
// rtl/baud_tick_controller.sv - UART baud timebase: divisor, oversample tick, TX tick, RX mid-bit strobe
module baud_tick_controller #(
  parameter int N         = 8,
  parameter int DIV_RESET = 163,
  parameter int OSR       = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         cfg_valid,
  input  logic [N-1:0] cfg_div,
  output logic         cfg_ready,
  input  logic         rx_align,
  output logic [N-1:0] div_cur,
  output logic         s_tick,
  output logic         tx_tick,
  output logic         rx_sample
);

  localparam int P = $clog2(OSR);
  localparam logic [P-1:0] TX_LAST = P'(OSR - 1);
  localparam logic [P-1:0] RX_MID  = P'(OSR / 2 - 1);

  typedef enum logic {IDLE, PEND} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic [N-1:0] div_cur_q, div_cur_d;
  logic [N-1:0] div_pend_q, div_pend_d;
  logic [P-1:0] tx_cnt_q, tx_cnt_d;
  logic [P-1:0] rx_cnt_q, rx_cnt_d;
  logic         s_tick_q, s_tick_d;
  logic         tx_tick_q, tx_tick_d;
  logic         rx_sample_q, rx_sample_d;
  logic         cfg_ready_q, cfg_ready_d;
  logic         tick_ev;

  // Divider, phase counters, pulse generation and divisor-change FSM
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_cur_d   = div_cur_q;
    div_pend_d  = div_pend_q;
    tx_cnt_d    = tx_cnt_q;
    rx_cnt_d    = rx_cnt_q;
    s_tick_d    = 1'b0;
    tx_tick_d   = 1'b0;
    rx_sample_d = 1'b0;

    tick_ev = en && (cnt_q == div_cur_q);

    if (en) begin
      cnt_d = tick_ev ? '0 : cnt_q + 1'b1;
    end

    if (tick_ev) begin
      s_tick_d  = 1'b1;
      tx_tick_d = (tx_cnt_q == TX_LAST);
      tx_cnt_d  = tx_cnt_q + 1'b1;
    end

    // Alignment takes priority over a coincident tick and swallows its sample
    if (rx_align) begin
      rx_cnt_d = '0;
    end else if (tick_ev) begin
      rx_sample_d = (rx_cnt_q == RX_MID);
      rx_cnt_d    = rx_cnt_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (cfg_valid && cfg_ready_q) begin
          div_pend_d = cfg_div;
          state_d    = PEND;
        end
      end
      PEND: begin
        // Running: wait for the current period to finish; stopped: apply now
        if (!en || tick_ev) begin
          div_cur_d = div_pend_q;
          cnt_d     = '0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    cfg_ready_d = (state_d == IDLE);
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      div_cur_q   <= N'(DIV_RESET);
      div_pend_q  <= '0;
      tx_cnt_q    <= '0;
      rx_cnt_q    <= '0;
      s_tick_q    <= 1'b0;
      tx_tick_q   <= 1'b0;
      rx_sample_q <= 1'b0;
      cfg_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_cur_q   <= div_cur_d;
      div_pend_q  <= div_pend_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      s_tick_q    <= s_tick_d;
      tx_tick_q   <= tx_tick_d;
      rx_sample_q <= rx_sample_d;
      cfg_ready_q <= cfg_ready_d;
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign div_cur   = div_cur_q;
  assign s_tick    = s_tick_q;
  assign tx_tick   = tx_tick_q;
  assign rx_sample = rx_sample_q;

endmodule

// File: tb/tb_baud_tick_controller.sv
// tb/tb_baud_tick_controller.sv - scoreboard bench for baud_tick_controller
module tb_baud_tick_controller;

  localparam int N   = 8;
  localparam int DR  = 163;
  localparam int OSR = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic         cfg_valid;
  logic [N-1:0] cfg_div;
  logic         cfg_ready;
  logic         rx_align;
  logic [N-1:0] div_cur;
  logic         s_tick;
  logic         tx_tick;
  logic         rx_sample;

  baud_tick_controller #(.N(N), .DIV_RESET(DR), .OSR(OSR)) dut (
    .clk(clk), .reset(reset), .en(en), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
    .cfg_ready(cfg_ready), .rx_align(rx_align), .div_cur(div_cur),
    .s_tick(s_tick), .tx_tick(tx_tick), .rx_sample(rx_sample)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   cyc;
    logic s;
    logic tx;
    logic rx;
  } pulse_t;

  typedef struct {
    int   div;
    logic rdy;
  } status_t;

  pulse_t  pq[$];
  status_t sq[$];

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  // Reference model: tick timing from elapsed enabled cycles, phases from tick counts
  int m_cyc  = 0;
  int m_el   = 0;
  int m_div  = DR;
  int m_pend = 0;
  int m_pval = 0;
  int m_ttot = 0;
  int m_tal  = 0;
  int m_rdy  = 0;

  task automatic model(input logic r, input logic e, input logic cv, input int cd, input logic ra);
    bit tick;
    int rdy_now;
    pulse_t  p;
    status_t s;
    m_cyc++;
    if (!r) begin
      m_el = 0; m_div = DR; m_pend = 0; m_ttot = 0; m_tal = 0; m_rdy = 0;
      s.div = DR; s.rdy = 1'b0;
      sq.push_back(s);
      return;
    end
    tick = e && (m_el == m_div);
    if (tick) begin
      p.cyc = m_cyc;
      p.s   = 1'b1;
      p.tx  = ((m_ttot % OSR) == OSR - 1);
      p.rx  = !ra && ((m_tal % OSR) == OSR / 2 - 1);
      pq.push_back(p);
    end
    rdy_now = m_rdy;
    if (e) m_el = tick ? 0 : m_el + 1;
    if (tick) m_ttot++;
    if (ra) m_tal = 0;
    else if (tick) m_tal++;
    if (m_pend != 0 && (!e || tick)) begin
      m_div = m_pval; m_el = 0; m_pend = 0;
    end else if (m_pend == 0 && rdy_now != 0 && cv) begin
      m_pend = 1; m_pval = cd;
    end
    m_rdy = (m_pend == 0);
    s.div = m_div; s.rdy = m_rdy[0];
    sq.push_back(s);
  endtask

  task automatic step(input logic r, input logic e, input logic cv, input int cd, input logic ra);
    reset = r; en = e; cfg_valid = cv; cfg_div = N'(cd); rx_align = ra;
    model(r, e, cv, cd, ra);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input logic e);
    for (int i = 0; i < n; i++) step(1'b1, e, 1'b0, 0, 1'b0);
  endtask

  // Monitor: status every cycle, pulse records whenever the DUT pulses
  always @(negedge clk) begin
    status_t s;
    pulse_t  p;
    if (sq.size() > 0) begin
      s = sq.pop_front();
      chk("div_cur", longint'(div_cur), longint'(s.div));
      chk("cfg_ready", longint'(cfg_ready), longint'(s.rdy));
    end
    if (s_tick === 1'b1 || tx_tick === 1'b1 || rx_sample === 1'b1) begin
      if (pq.size() == 0) begin
        chk("unexpected_pulse", longint'({s_tick, tx_tick, rx_sample}), 0);
      end else begin
        p = pq.pop_front();
        chk("pulse_cycle", longint'(cyc), longint'(p.cyc));
        chk("pulse_flags", longint'({s_tick, tx_tick, rx_sample}), longint'({p.s, p.tx, p.rx}));
      end
    end
  end

  initial begin
    reset = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0; rx_align = 1'b0;

    // Defaults: first s_tick at 164, tx_tick at every 16th
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 0, 1'b0);
    run(2700, 1'b1);

    // Divisor change mid-period
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 0, 1'b0);
    run(50, 1'b1);
    step(1'b1, 1'b1, 1'b1, 9, 1'b0);
    run(300, 1'b1);

    // RX alignment with divisor 3, including align on a tick
    step(1'b1, 1'b1, 1'b1, 3, 1'b0);
    run(60, 1'b1);
    step(1'b1, 1'b1, 1'b0, 0, 1'b1);
    run(200, 1'b1);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b0, 0, (i == 31));
    run(200, 1'b1);

    // Pause with en=0 and apply while stopped
    step(1'b1, 1'b1, 1'b1, 9, 1'b0);
    run(35, 1'b1);
    run(20, 1'b0);
    run(40, 1'b1);
    run(3, 1'b0);
    step(1'b1, 1'b0, 1'b1, 5, 1'b0);
    run(3, 1'b0);
    run(60, 1'b1);

    // Divisor 0: tick every cycle
    step(1'b1, 1'b1, 1'b1, 0, 1'b0);
    run(10, 1'b1);
    step(1'b1, 1'b1, 1'b0, 0, 1'b1);
    run(60, 1'b1);

    // Reset while a change is pending
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 0, 1'b0);
    run(20, 1'b1);
    step(1'b1, 1'b1, 1'b1, 7, 1'b0);
    run(5, 1'b1);
    step(1'b0, 1'b1, 1'b0, 0, 1'b0);
    run(400, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 8000; i++) begin
      step(($urandom_range(0, 1500) != 0),
           ($urandom_range(0, 15) != 0),
           ($urandom_range(0, 40) == 0),
           int'($urandom_range(0, 12)),
           ($urandom_range(0, 60) == 0));
    end

    run(2, 1'b0);
    @(negedge clk);
    #1;
    chk("pulse_leftover", longint'(pq.size()), 0);
    chk("status_leftover", longint'(sq.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/baud_tick_controller.md
Name: baud_tick_controller

Overview:
Run-time controller for the UART baud timebase. It owns the clock divisor and produces the 16x oversample tick. It derives the per-bit transmit tick and the mid-bit receive sample strobe from that tick, with receive phase alignment on start-bit detection. Divisor changes go through a valid/ready handshake and take effect only at a tick boundary, so no short or long tick is ever produced.

Parameters:
N, 8, divisor counter and divisor width in bits
DIV_RESET, 163, divisor loaded at reset; tick period = DIV_RESET+1 clk cycles
OSR, 16, oversample ratio; power of two, >= 4; phase counters are clog2(OSR) bits

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset (0 = reset asserted, sampled on clk rising edge)
en  input  1  timebase run enable
cfg_valid  input  1  new divisor offered
cfg_div  input  N  new divisor value
cfg_ready  output  1  divisor capture possible
rx_align  input  1  one-cycle pulse from RX start-bit detect; re-phases the RX sample strobe
div_cur  output  N  divisor currently in effect
s_tick  output  1  oversample tick, one-cycle pulse
tx_tick  output  1  TX bit-period tick, one-cycle pulse
rx_sample  output  1  RX mid-bit sample strobe, one-cycle pulse

Behaviour:
- Reset (reset=0 at a clk edge) sets the following; a pending configuration is discarded:
  - cnt=0, div_cur=DIV_RESET, tx_cnt=0, rx_cnt=0
  - s_tick=tx_tick=rx_sample=0
  - state=IDLE, cfg_ready=0 while reset=0
- All outputs are registered.
- Divider, per cycle with en=1:
  - If cnt==div_cur: cnt<=0 and a tick event occurs; s_tick=1 in the next cycle.
  - Otherwise cnt<=cnt+1.
  - Period is div_cur+1 cycles.
  - With en=1 held from the first cycle after reset, the first s_tick appears in cycle div_cur+1.
  - div_cur=0 gives s_tick high every cycle.
  - Counter compare is unsigned N-bit; cnt never exceeds div_cur.
- en=0: cnt, tx_cnt and rx_cnt hold; no tick events; all pulse outputs are 0 the next cycle.
- Config FSM:
  - IDLE: cfg_ready=1. cfg_valid&cfg_ready captures cfg_div into div_pend; next state PEND.
  - PEND: cfg_ready=0.
    - If en=1, at the next tick event: div_cur<=div_pend, cnt<=0, next state IDLE. The old period completes and its s_tick is still issued.
    - If en=0: apply at the next clk edge (div_cur<=div_pend, cnt<=0), next state IDLE.
  - cfg_ready returns to 1 in the cycle after the apply.
  - cfg_div is don't-care when no handshake occurs.
- TX phase, on each tick event: tx_cnt<=tx_cnt+1 modulo OSR. tx_tick=1 together with s_tick when tx_cnt was OSR-1. TX bit period = OSR*(div_cur+1) cycles.
- RX phase, on each tick event: rx_cnt<=rx_cnt+1 modulo OSR. rx_sample=1 together with s_tick when rx_cnt was OSR/2-1.
  - First sample comes OSR/2 ticks after alignment, then every OSR ticks.
  - rx_align=1: rx_cnt<=0.
  - If rx_align coincides with a tick event, align wins: rx_cnt<=0 and that event produces no rx_sample (s_tick and tx_tick unaffected).
  - rx_align is honoured regardless of en.
- Divisor change does not reset tx_cnt or rx_cnt.
- Simultaneous cfg handshake and tick event in IDLE: capture only; apply at the following tick event.

Test Plan:
- Reset release, en=1, defaults: s_tick first high in cycle 164, then every 164 cycles. tx_tick coincides with every 16th s_tick (every 2624 cycles). div_cur=163, cfg_ready=1.
- With cnt=50, handshake cfg_div=9: cfg_ready=0; the current period completes with s_tick at cycle 164. Subsequent s_tick period is 10 cycles; div_cur=9 the cycle after apply; cfg_ready=1 again.
- div_cur=3: pulse rx_align. The 8th s_tick after align carries rx_sample, then every 16th; a pulse of rx_align coincident with a tick suppresses that rx_sample.
- en dropped for 20 cycles mid-period with div_cur=9: no pulses; the period resumes where it paused (total gap = 10+20 cycles). Handshake cfg_div=5 while en=0: applies next cycle; cnt=0.
- cfg_div=0, en=1: s_tick constant 1; tx_tick every 16 cycles; rx_sample every 16 cycles, offset 8 from align.
- reset=0 asserted while in PEND with cfg_div=7 captured: div_cur=163, state=IDLE, all pulses 0; pending value never applied.
